// File: rtl/gate_sweep_if.sv
// gate_sweep bus: sweep control, gate-under-test hookup and result status.
// master = controller/gate side, slave = the sweeper.
interface gate_sweep_if #(
  parameter int N     = 2,
  parameter int CNT_W = 8
);
  logic             start;
  logic [2:0]       mode;
  logic             dut_o;
  logic [N-1:0]     a_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic             mode_err;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [N-1:0]     fail_vec;

  modport master (
    output start, mode, dut_o,
    input  a_out, busy, done, pass, mode_err,
    input  err_cnt, fail_valid, fail_vec
  );

  modport slave (
    input  start, mode, dut_o,
    output a_out, busy, done, pass, mode_err,
    output err_cnt, fail_valid, fail_vec
  );
endinterface

// File: rtl/gate_sweep.sv
// Exhaustive truth-table sweeper/checker for an external N-input gate.
// Drives 0..2^N-1, samples dut_o after SETTLE cycles, tallies mismatches.
module gate_sweep #(
  parameter int N      = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8
) (
  input  logic      clk,
  input  logic      rst,
  gate_sweep_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'(SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           nxt;
  logic [N-1:0]     v;
  logic [SW-1:0]    set_cnt;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [N-1:0]     fail_vec;
  logic             pass;
  logic             mode_err;
  logic             busy;
  logic             done;

  logic legal;
  logic go;
  logic settled;
  logic last;
  logic ref_bit;
  logic miss;

  // Golden value of the selected function for one input vector.
  function automatic logic ref_of(
    input logic [2:0]   m,
    input logic [N-1:0] x
  );
    logic r;
    unique case (m)
      3'd0:    r = ~|x;
      3'd1:    r = |x;
      3'd2:    r = ~&x;
      3'd3:    r = &x;
      3'd4:    r = ^x;
      3'd5:    r = ~^x;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign legal   = (bus.mode <= 3'd5);
  assign go      = (state == S_IDLE) && bus.start;
  assign settled = (set_cnt == SET_LAST);
  assign last    = &v;
  assign ref_bit = ref_of(mode_q, v);
  assign miss    = (state == S_SAMPLE) && (bus.dut_o != ref_bit);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next-state: hold each vector SETTLE cycles, sample once, advance.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          nxt = legal ? S_DRIVE : S_DONE;
        end
      end
      S_DRIVE: begin
        if (settled) begin
          nxt = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        nxt = last ? S_DONE : S_DRIVE;
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == S_DRIVE):  busy = 1'b1;
      (state == S_SAMPLE): busy = 1'b1;
      (state == S_DONE):   done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Vector, settle timer and latched mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v       <= '0;
      set_cnt <= '0;
      mode_q  <= '0;
    end else begin
      if (go && legal) begin
        mode_q  <= bus.mode;
        v       <= '0;
        set_cnt <= '0;
      end else if (state == S_DRIVE) begin
        set_cnt <= settled ? '0 : set_cnt + SW'(1);
      end else if (state == S_SAMPLE && !last) begin
        v <= v + N'(1);
      end
    end
  end

  // Result status; pass is resolved on entry to DONE so it is
  // valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      pass       <= 1'b0;
      mode_err   <= 1'b0;
    end else if (go) begin
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      pass       <= 1'b0;
      mode_err   <= !legal;
    end else if (state == S_SAMPLE) begin
      if (miss) begin
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        if (!fail_valid) begin
          fail_vec   <= v;
          fail_valid <= 1'b1;
        end
      end
      if (last) begin
        pass <= (err_cnt == '0) && !miss && !mode_err;
      end
    end
  end

  assign bus.a_out      = v;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.mode_err   = mode_err;
  assign bus.err_cnt    = err_cnt;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule
